// File: rtl/audio_key_ctrl_pkg.sv
// audio_key_ctrl_pkg: shared FSM state encoding and slot-width helper for the record/playback controller
package audio_key_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, WLOAD, REC, HOLD, RLOAD, PLAY} state_t;
  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/audio_key_ctrl_if.sv
// audio_key_ctrl_if: board-key/DDR-gate inputs and record/playback control outputs
interface audio_key_ctrl_if
  import audio_key_ctrl_pkg::*;
#(parameter int KEY_NUM = 4, parameter int SLOT_W = slot_w(KEY_NUM));
  logic               ddr_init_done;
  logic [KEY_NUM-1:0] key;
  logic               record_en;
  logic               play_en;
  logic               wr_load;
  logic               rd_load;
  logic [SLOT_W-1:0]  slot;
  logic               busy;
  logic               rec_full;
  logic               play_done;
  modport slave(input ddr_init_done, key,
                output record_en, play_en, wr_load, rd_load, slot, busy, rec_full, play_done);
  modport master(output ddr_init_done, key,
                 input record_en, play_en, wr_load, rd_load, slot, busy, rec_full, play_done);
endinterface

// File: rtl/audio_key_ctrl_key_debounce.sv
// key_debounce: 2-flop sync of one active-low key, tick-sampled debounce, registered press/release pulses
module key_debounce #(parameter int DEB_TICKS = 4) (
  input  logic clk50M,
  input  logic reset_n,
  input  logic i_tick,
  input  logic i_key,
  output logic o_press,
  output logic o_release
);
  localparam int CW = $clog2(DEB_TICKS) + 1;
  logic [1:0]    r_sync;
  logic          r_deb;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk50M) begin
    if (!reset_n) begin
      r_sync    <= 2'b11;
      r_deb     <= 1'b1;
      r_cnt     <= '0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_key};
      o_press   <= 1'b0;
      o_release <= 1'b0;
      if (i_tick) begin
        if (r_sync[1] == r_deb) r_cnt <= '0;
        else if (r_cnt == CW'(DEB_TICKS - 1)) begin
          r_cnt     <= '0;
          r_deb     <= r_sync[1];
          o_press   <= ~r_sync[1];
          o_release <= r_sync[1];
        end else r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/audio_key_ctrl.sv
// audio_key_ctrl: multi-slot push-to-talk record/playback FSM driving DDR FIFO loaders, gated by DDR init
module audio_key_ctrl
  import audio_key_ctrl_pkg::*;
#(
  parameter int CLK_DIV_W = 16,
  parameter int KEY_NUM   = 4,
  parameter int DEB_TICKS = 4,
  parameter int LEN_W     = 32
) (
  input logic              clk50M,
  input logic              reset_n,
  audio_key_ctrl_if.slave  bus
);
  localparam int SLOT_W = slot_w(KEY_NUM);
  localparam logic [LEN_W-1:0] MAX_LEN = '1;

  logic [CLK_DIV_W-1:0] r_div;
  logic                 w_tick;
  logic [KEY_NUM-1:0]   w_press, w_rel;
  logic [SLOT_W-1:0]    w_low;
  state_t               r_state, w_next;
  logic [SLOT_W-1:0]    r_slot;
  logic [LEN_W-1:0]     r_len, r_play;
  logic [LEN_W-1:0]     r_slot_len [KEY_NUM];
  logic w_rec, w_play, w_wr, w_rd, w_full, w_done;
  logic r_record_en, r_play_en, r_wr_load, r_rd_load, r_busy, r_rec_full, r_play_done;

  assign w_tick = &r_div;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
      .clk50M   (clk50M),
      .reset_n  (reset_n),
      .i_tick   (w_tick),
      .i_key    (bus.key[g]),
      .o_press  (w_press[g]),
      .o_release(w_rel[g])
    );
  end

  always_comb begin
    w_low = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) if (w_press[i]) w_low = SLOT_W'(i);
  end

  always_comb begin
    w_next = r_state;
    w_rec  = 1'b0;
    w_play = 1'b0;
    w_wr   = 1'b0;
    w_rd   = 1'b0;
    w_full = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE:  w_next = (|w_press) ? WLOAD : IDLE;
      WLOAD: begin
        w_wr   = 1'b1;
        w_next = REC;
      end
      REC: begin
        w_rec = 1'b1;
        if (w_rel[r_slot]) w_next = RLOAD;
        else if (r_len == MAX_LEN) begin
          w_rec  = 1'b0;
          w_full = 1'b1;
          w_next = HOLD;
        end
      end
      HOLD:  w_next = w_rel[r_slot] ? RLOAD : HOLD;
      RLOAD: begin
        w_rd   = 1'b1;
        w_done = (r_slot_len[r_slot] == '0);
        w_next = w_done ? IDLE : PLAY;
      end
      PLAY: begin
        w_play = 1'b1;
        if (|w_press) begin
          w_play = 1'b0;
          w_next = WLOAD;
        end else if (r_play == r_slot_len[r_slot]) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    // losing DDR kills the operation silently: no pulses, enables drop
    if (!bus.ddr_init_done) begin
      w_next = IDLE;
      {w_rec, w_play, w_wr, w_rd, w_full, w_done} = '0;
    end
  end

  always_ff @(posedge clk50M) begin
    if (!reset_n) begin
      r_div   <= '0;
      r_state <= IDLE;
      r_slot  <= '0;
      r_len   <= '0;
      r_play  <= '0;
      for (int i = 0; i < KEY_NUM; i++) r_slot_len[i] <= '0;
      {r_record_en, r_play_en, r_wr_load, r_rd_load, r_busy, r_rec_full, r_play_done} <= '0;
    end else begin
      r_div       <= r_div + 1'b1;
      r_state     <= w_next;
      r_record_en <= w_rec;
      r_play_en   <= w_play;
      r_wr_load   <= w_wr;
      r_rd_load   <= w_rd;
      r_rec_full  <= w_full;
      r_play_done <= w_done;
      r_busy      <= (w_next != IDLE);
      if (w_next == WLOAD) r_slot <= w_low;
      if (r_state == WLOAD) r_len <= '0;
      else if (r_state == REC && w_tick && r_len != MAX_LEN) r_len <= r_len + 1'b1;
      if (r_state == RLOAD) r_play <= '0;
      else if (r_state == PLAY && w_tick) r_play <= r_play + 1'b1;
      if (r_state == REC && w_next == RLOAD) r_slot_len[r_slot] <= r_len;
      if (w_full) r_slot_len[r_slot] <= MAX_LEN;
    end
  end

  assign bus.record_en = r_record_en;
  assign bus.play_en   = r_play_en;
  assign bus.wr_load   = r_wr_load;
  assign bus.rd_load   = r_rd_load;
  assign bus.slot      = r_slot;
  assign bus.busy      = r_busy;
  assign bus.rec_full  = r_rec_full;
  assign bus.play_done = r_play_done;
endmodule

// File: tb/tb_audio_key_ctrl.sv
// tb_audio_key_ctrl: directed scenario bench for the push-to-talk record/playback controller
module tb_audio_key_ctrl;
  localparam int TPC = 16;
  logic clk50M = 1'b0;
  logic reset_n = 1'b0;
  int vecs = 0, errs = 0;
  int n_wr = 0, n_rd = 0, n_done = 0, n_full = 0, n_rec = 0, n_play = 0, n_busy = 0, wr_slot = -1;
  int s_wr, s_rd, s_done, s_full, s_rec, s_play, s_busy;
  logic pe_at_wr = 1'b0;
  logic [3:0] tdiv;

  audio_key_ctrl_if #(.KEY_NUM(4)) bus ();
  audio_key_ctrl #(.CLK_DIV_W(4), .KEY_NUM(4), .DEB_TICKS(2), .LEN_W(8)) dut (
    .clk50M (clk50M),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk50M = ~clk50M;

  // reference tick: free-running 4-bit divider cleared by reset
  always @(posedge clk50M) tdiv <= !reset_n ? 4'd0 : tdiv + 4'd1;

  always @(negedge clk50M) begin
    if (bus.wr_load === 1'b1) begin
      n_wr++;
      wr_slot = int'(bus.slot);
      pe_at_wr = bus.play_en;
    end
    if (bus.rd_load === 1'b1) n_rd++;
    if (bus.play_done === 1'b1) n_done++;
    if (bus.rec_full === 1'b1) n_full++;
    if (bus.busy === 1'b1) n_busy++;
    if (tdiv == 4'hF && bus.record_en === 1'b1) n_rec++;
    if (tdiv == 4'hF && bus.play_en === 1'b1) n_play++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_ticks(input int n);
    repeat (n * TPC) @(negedge clk50M);
  endtask

  task automatic snap();
    s_wr = n_wr; s_rd = n_rd; s_done = n_done; s_full = n_full;
    s_rec = n_rec; s_play = n_play; s_busy = n_busy;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (bus.busy === 1'b1 && k < budget) begin
      @(negedge clk50M);
      k++;
    end
    vecs++;
    if (bus.busy !== 1'b0) begin errs++; $display("FAIL %s_idle: busy=%b required 0 after %0d cycles", name, bus.busy, k); end
    wait_ticks(1);
  endtask

  task automatic test_reset();
    vecs++;
    if ({bus.record_en, bus.play_en, bus.wr_load, bus.rd_load, bus.busy, bus.rec_full, bus.play_done} !== 7'd0) begin
      errs++; $display("FAIL reset_flags: got %b required 0000000", {bus.record_en, bus.play_en, bus.wr_load, bus.rd_load, bus.busy, bus.rec_full, bus.play_done});
    end
    vecs++;
    if (bus.slot !== 2'd0) begin errs++; $display("FAIL reset_slot: got %0d required 0", bus.slot); end
  endtask

  task automatic test_gate();
    snap();
    bus.key[0] = 1'b0;
    wait_ticks(20);
    vecs++;
    if (bus.record_en !== 1'b0) begin errs++; $display("FAIL gate_record_en: got %b required 0", bus.record_en); end
    bus.key[0] = 1'b1;
    wait_ticks(4);
    vecs++;
    if (n_wr - s_wr !== 0) begin errs++; $display("FAIL gate_wr_load: got %0d pulses required 0", n_wr - s_wr); end
    vecs++;
    if (n_busy - s_busy !== 0) begin errs++; $display("FAIL gate_busy: got %0d busy cycles required 0", n_busy - s_busy); end
    bus.ddr_init_done = 1'b1;
    wait_ticks(2);
  endtask

  task automatic test_basic();
    snap();
    bus.key[1] = 1'b0;
    wait_ticks(50);
    bus.key[1] = 1'b1;
    wait_idle("basic", 3000);
    vecs++;
    if (n_wr - s_wr !== 1) begin errs++; $display("FAIL basic_wr_load: got %0d required 1", n_wr - s_wr); end
    vecs++;
    if (wr_slot !== 1) begin errs++; $display("FAIL basic_slot: got %0d required 1", wr_slot); end
    vecs++;
    if (n_rec - s_rec !== 50) begin errs++; $display("FAIL basic_rec_ticks: got %0d required 50", n_rec - s_rec); end
    vecs++;
    if (n_rd - s_rd !== 1) begin errs++; $display("FAIL basic_rd_load: got %0d required 1", n_rd - s_rd); end
    vecs++;
    if (n_play - s_play !== 50) begin errs++; $display("FAIL basic_play_ticks: got %0d required 50", n_play - s_play); end
    vecs++;
    if (n_done - s_done !== 1) begin errs++; $display("FAIL basic_play_done: got %0d required 1", n_done - s_done); end
  endtask

  task automatic test_bounce();
    snap();
    for (int i = 0; i < 10; i++) begin
      bus.key[2] = 1'b0;
      wait_ticks(1);
      bus.key[2] = 1'b1;
      wait_ticks(1);
    end
    wait_ticks(4);
    vecs++;
    if (n_busy - s_busy !== 0) begin errs++; $display("FAIL bounce_busy: got %0d busy cycles required 0", n_busy - s_busy); end
    vecs++;
    if (n_wr - s_wr !== 0) begin errs++; $display("FAIL bounce_wr_load: got %0d required 0", n_wr - s_wr); end
  endtask

  task automatic test_tie();
    snap();
    bus.key[2] = 1'b0;
    bus.key[3] = 1'b0;
    wait_ticks(10);
    bus.key[3] = 1'b1;
    wait_ticks(10);
    vecs++;
    if (bus.record_en !== 1'b1) begin errs++; $display("FAIL tie_still_rec: got %b required 1", bus.record_en); end
    bus.key[2] = 1'b1;
    wait_idle("tie", 2000);
    vecs++;
    if (wr_slot !== 2) begin errs++; $display("FAIL tie_slot: got %0d required 2", wr_slot); end
    vecs++;
    if (n_rec - s_rec !== 20) begin errs++; $display("FAIL tie_rec_ticks: got %0d required 20", n_rec - s_rec); end
    vecs++;
    if (n_play - s_play !== 20) begin errs++; $display("FAIL tie_play_ticks: got %0d required 20", n_play - s_play); end
  endtask

  task automatic test_saturate();
    snap();
    bus.key[0] = 1'b0;
    wait_ticks(300);
    vecs++;
    if (n_full - s_full !== 1) begin errs++; $display("FAIL sat_rec_full: got %0d required 1", n_full - s_full); end
    vecs++;
    if (n_rec - s_rec !== 255) begin errs++; $display("FAIL sat_rec_ticks: got %0d required 255", n_rec - s_rec); end
    vecs++;
    if ({bus.record_en, bus.busy} !== 2'b01) begin errs++; $display("FAIL sat_hold: got record_en,busy=%b required 01", {bus.record_en, bus.busy}); end
    bus.key[0] = 1'b1;
    wait_idle("sat", 6000);
    vecs++;
    if (n_play - s_play !== 255) begin errs++; $display("FAIL sat_play_ticks: got %0d required 255", n_play - s_play); end
    vecs++;
    if (n_done - s_done !== 1) begin errs++; $display("FAIL sat_play_done: got %0d required 1", n_done - s_done); end
  endtask

  task automatic test_abort();
    int k = 0;
    bus.key[1] = 1'b0;
    wait_ticks(30);
    bus.key[1] = 1'b1;
    while (bus.play_en !== 1'b1 && k < 200) begin
      @(negedge clk50M);
      k++;
    end
    vecs++;
    if (bus.play_en !== 1'b1) begin errs++; $display("FAIL abort_play_start: play_en=%b required 1", bus.play_en); end
    wait_ticks(10);
    snap();
    bus.key[0] = 1'b0;
    wait_ticks(4);
    vecs++;
    if (n_wr - s_wr !== 1) begin errs++; $display("FAIL abort_wr_load: got %0d required 1", n_wr - s_wr); end
    vecs++;
    if (wr_slot !== 0) begin errs++; $display("FAIL abort_slot: got %0d required 0", wr_slot); end
    vecs++;
    if (pe_at_wr !== 1'b0) begin errs++; $display("FAIL abort_play_en: got %b required 0", pe_at_wr); end
    vecs++;
    if (n_done - s_done !== 0) begin errs++; $display("FAIL abort_no_done: got %0d required 0", n_done - s_done); end
    wait_ticks(4);
    bus.key[0] = 1'b1;
    wait_idle("abort", 2000);
    vecs++;
    if (n_done - s_done !== 1) begin errs++; $display("FAIL abort_final_done: got %0d required 1", n_done - s_done); end
  endtask

  task automatic test_ddr_drop();
    bus.key[1] = 1'b0;
    wait_ticks(6);
    vecs++;
    if (bus.record_en !== 1'b1) begin errs++; $display("FAIL ddr_pre_rec: got %b required 1", bus.record_en); end
    bus.ddr_init_done = 1'b0;
    @(negedge clk50M);
    vecs++;
    if ({bus.record_en, bus.busy} !== 2'b00) begin errs++; $display("FAIL ddr_drop: got record_en,busy=%b required 00", {bus.record_en, bus.busy}); end
    bus.ddr_init_done = 1'b1;
    wait_ticks(4);
    bus.key[1] = 1'b1;
    wait_ticks(4);
    vecs++;
    if (bus.busy !== 1'b0) begin errs++; $display("FAIL ddr_after: busy=%b required 0", bus.busy); end
  endtask

  task automatic test_reset_mid_rec();
    bus.key[3] = 1'b0;
    wait_ticks(8);
    vecs++;
    if (bus.record_en !== 1'b1) begin errs++; $display("FAIL rst_pre_rec: got %b required 1", bus.record_en); end
    reset_n = 1'b0;
    @(negedge clk50M);
    vecs++;
    if ({bus.record_en, bus.play_en, bus.wr_load, bus.rd_load, bus.busy, bus.rec_full, bus.play_done, bus.slot} !== 9'd0) begin
      errs++; $display("FAIL rst_mid_rec: got %b required 000000000", {bus.record_en, bus.play_en, bus.wr_load, bus.rd_load, bus.busy, bus.rec_full, bus.play_done, bus.slot});
    end
    reset_n = 1'b1;
    snap();
    wait_ticks(5);
    vecs++;
    if (n_wr - s_wr !== 1 || wr_slot !== 3) begin errs++; $display("FAIL rst_repress: got %0d pulses slot %0d required 1 slot 3", n_wr - s_wr, wr_slot); end
    bus.key[3] = 1'b1;
    wait_idle("rst", 2000);
  endtask

  initial begin
    bus.ddr_init_done = 1'b0;
    bus.key = 4'hF;
    repeat (3) @(negedge clk50M);
    reset_n = 1'b1;
    test_reset();
    test_gate();
    test_basic();
    test_bounce();
    test_tie();
    test_saturate();
    test_abort();
    test_ddr_drop();
    test_reset_mid_rec();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
